// File: rtl/vga_timing_gen_if.sv
// Raster interface between the VGA timing source and the pixel-path renderers.
// Latency: none (signal bundle only).
// Backpressure: none; the raster is free-running and consumers must keep up.
//
// Signals:
//   hs, vs        sync outputs to the DAC/connector, polarity set by the source
//   blank         1 = visible pixel, 0 = blanking
//   sync          composite sync for the DAC, held low
//   DrawX, DrawY  current raster position, not clamped during blanking
//   line_start    one-cycle pulse at DrawX == 0
//   frame_start   one-cycle pulse at DrawX == 0 && DrawY == 0
//   frame_count   frames started mod 256, present only with FRAME_COUNTER_EN
// Modports: master = timing generator (drives everything), slave = renderer.
interface vga_timing_gen_if;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       line_start;
    logic       frame_start;
`ifdef FRAME_COUNTER_EN
    logic [7:0] frame_count;
`endif

    modport master (
`ifdef FRAME_COUNTER_EN
        output frame_count,
`endif
        output hs, vs, blank, sync, DrawX, DrawY, line_start, frame_start
    );

    modport slave (
`ifdef FRAME_COUNTER_EN
        input frame_count,
`endif
        input hs, vs, blank, sync, DrawX, DrawY, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: free-running H/V counters, sync, blank and pixel coordinates.
// Latency: every output is a register loaded from the same next (x, y); all outputs are aligned.
// Backpressure: none; consumers sample DrawX/DrawY/blank every pixel clock.
//
// Ports:
//   vga_clk   in   pixel clock, the only clock
//   Reset     in   synchronous active-high reset
//   o_vga     vga_timing_gen_if.master: hs, vs, blank, sync, DrawX, DrawY,
//             line_start, frame_start (+ frame_count when FRAME_COUNTER_EN is defined)
// Optional feature macro: FRAME_COUNTER_EN adds an 8-bit frames-started counter.
// Default mode is 640x480@60 with a 25 MHz pixel clock; both totals must fit 10 bits.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             vga_clk,
    input  logic             Reset,
    vga_timing_gen_if.master o_vga
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Counters and coordinates are 10 bits wide; larger modes cannot be represented.
    generate
        if (H_TOTAL > 1024) begin : g_h_total_too_big
            $error("vga_timing_gen: H_TOTAL %0d exceeds 1024", H_TOTAL);
        end
        if (V_TOTAL > 1024) begin : g_v_total_too_big
            $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
        end
    endgenerate

    // Raster position counters. Reset presets them to the last pixel of the
    // frame so that the first edge after release lands on (0, 0).
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    // Registered outputs.
    logic [9:0] r_draw_x;
    logic [9:0] r_draw_y;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_line_start;
    logic       r_frame_start;

    // Next raster position and everything decoded from it.
    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic       w_blank;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_line_start;
    logic       w_frame_start;

    always_comb begin
        w_h_nxt = r_h_cnt + 10'd1;
        w_v_nxt = r_v_cnt;
        if (r_h_cnt == H_LAST) begin
            w_h_nxt = 10'd0;
            if (r_v_cnt == V_LAST) begin
                w_v_nxt = 10'd0;
            end else begin
                w_v_nxt = r_v_cnt + 10'd1;
            end
        end
    end

    // Decode from the next position so the strobes line up with the DrawX/DrawY
    // value they describe. Compares are done one bit wider so that a visible or
    // sync boundary equal to 1024 still decodes correctly.
    always_comb begin
        w_x_ext       = {1'b0, w_h_nxt};
        w_y_ext       = {1'b0, w_v_nxt};
        w_blank       = (w_x_ext < 11'(H_VISIBLE)) && (w_y_ext < 11'(V_VISIBLE));
        w_hs_act      = (w_x_ext >= 11'(HS_START)) && (w_x_ext < 11'(HS_END));
        // vs depends on y only, so it covers whole lines including their blanking.
        w_vs_act      = (w_y_ext >= 11'(VS_START)) && (w_y_ext < 11'(VS_END));
        w_line_start  = (w_h_nxt == 10'd0);
        w_frame_start = (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            r_draw_x      <= 10'd0;
            r_draw_y      <= 10'd0;
            r_blank       <= 1'b0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_draw_x      <= w_h_nxt;
            r_draw_y      <= w_v_nxt;
            r_blank       <= w_blank;
            r_hs          <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vs          <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

`ifdef FRAME_COUNTER_EN
    // Counts frame_start loads, so the first frame after reset reads 1.
    logic [7:0] r_frame_cnt;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign o_vga.frame_count = r_frame_cnt;
`endif

    assign o_vga.DrawX       = r_draw_x;
    assign o_vga.DrawY       = r_draw_y;
    assign o_vga.blank       = r_blank;
    assign o_vga.hs          = r_hs;
    assign o_vga.vs          = r_vs;
    assign o_vga.line_start  = r_line_start;
    assign o_vga.frame_start = r_frame_start;
    // The DAC composite-sync input is unused in this design.
    assign o_vga.sync        = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a tiny active-high-sync
// instance (16x10 totals) share one clock and reset, so full frames fit a short run.
// Expected outputs are pushed to a queue per instance before each edge and popped after it.
module tb_vga_timing_gen;

    localparam int S_HV  = 8;
    localparam int S_HFP = 2;
    localparam int S_HS  = 3;
    localparam int S_HBP = 3;
    localparam int S_VV  = 6;
    localparam int S_VFP = 1;
    localparam int S_VS  = 2;
    localparam int S_VBP = 1;

    logic vga_clk = 1'b0;
    logic Reset   = 1'b1;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();

    vga_timing_gen u_dut_d (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .o_vga   (if_d)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV),
        .H_FP      (S_HFP),
        .H_SYNC    (S_HS),
        .H_BP      (S_HBP),
        .V_VISIBLE (S_VV),
        .V_FP      (S_VFP),
        .V_SYNC    (S_VS),
        .V_BP      (S_VBP),
        .SYNC_POL  (1'b1)
    ) u_dut_s (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .o_vga   (if_s)
    );

    typedef struct {
        int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
        bit pol;
    } tcfg_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       sync;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    tcfg_t      cfg_d, cfg_s;
    int         mx_d, my_d, mx_s, my_s;
    logic [7:0] fc_d, fc_s;
    exp_t       q_d[$];
    exp_t       q_s[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference raster: advance one edge and produce the outputs that edge should load.
    task automatic model_step(input tcfg_t c, input logic rst, inout int mx, inout int my,
                              inout logic [7:0] fc, output exp_t e);
        int htot, vtot;
        htot = c.hv + c.hfp + c.hsw + c.hbp;
        vtot = c.vv + c.vfp + c.vsw + c.vbp;
        e = '0;
        if (rst) begin
            mx   = htot - 1;
            my   = vtot - 1;
            fc   = 8'd0;
            e.hs = ~c.pol;
            e.vs = ~c.pol;
        end else begin
            if (mx == htot - 1) begin
                mx = 0;
                my = (my == vtot - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            e.x     = 10'(mx);
            e.y     = 10'(my);
            e.blank = (mx < c.hv) && (my < c.vv);
            e.hs    = (mx >= c.hv + c.hfp && mx < c.hv + c.hfp + c.hsw) ? c.pol : ~c.pol;
            e.vs    = (my >= c.vv + c.vfp && my < c.vv + c.vfp + c.vsw) ? c.pol : ~c.pol;
            e.ls    = (mx == 0);
            e.fs    = (mx == 0) && (my == 0);
            if (e.fs) fc = fc + 8'd1;
        end
        e.fc = fc;
    endtask

    task automatic cmp(input string inst, input exp_t e, input exp_t a);
        check({inst, "_DrawX"},       32'(a.x),     32'(e.x));
        check({inst, "_DrawY"},       32'(a.y),     32'(e.y));
        check({inst, "_blank"},       32'(a.blank), 32'(e.blank));
        check({inst, "_hs"},          32'(a.hs),    32'(e.hs));
        check({inst, "_vs"},          32'(a.vs),    32'(e.vs));
        check({inst, "_sync"},        32'(a.sync),  32'(e.sync));
        check({inst, "_line_start"},  32'(a.ls),    32'(e.ls));
        check({inst, "_frame_start"}, 32'(a.fs),    32'(e.fs));
`ifdef FRAME_COUNTER_EN
        check({inst, "_frame_count"}, 32'(a.fc),    32'(e.fc));
`endif
    endtask

    task automatic pop_cmp(input string inst, inout exp_t q[$], input exp_t a);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed empty expected entry", inst);
        end else begin
            e = q.pop_front();
            cmp(inst, e, a);
        end
    endtask

    // One pixel clock: drive Reset, queue both predictions, sample 1 unit after the edge.
    task automatic step(input logic rst);
        exp_t e, a;
        Reset = rst;
        model_step(cfg_d, rst, mx_d, my_d, fc_d, e);
        q_d.push_back(e);
        model_step(cfg_s, rst, mx_s, my_s, fc_s, e);
        q_s.push_back(e);
        @(posedge vga_clk);
        #1;
        a = '0;
        a.x = if_d.DrawX; a.y = if_d.DrawY; a.blank = if_d.blank; a.hs = if_d.hs;
        a.vs = if_d.vs; a.sync = if_d.sync; a.ls = if_d.line_start; a.fs = if_d.frame_start;
`ifdef FRAME_COUNTER_EN
        a.fc = if_d.frame_count;
`endif
        pop_cmp("d", q_d, a);
        a = '0;
        a.x = if_s.DrawX; a.y = if_s.DrawY; a.blank = if_s.blank; a.hs = if_s.hs;
        a.vs = if_s.vs; a.sync = if_s.sync; a.ls = if_s.line_start; a.fs = if_s.frame_start;
`ifdef FRAME_COUNTER_EN
        a.fc = if_s.frame_count;
`endif
        pop_cmp("s", q_s, a);
    endtask

    task automatic run_until_x(input int target, input int budget);
        int n;
        n = 0;
        while (int'(if_d.DrawX) != target && n < budget) begin
            step(1'b0);
            n++;
        end
        check("d_wait_x", 32'(if_d.DrawX), 32'(target));
    endtask

    initial begin
        int hs_cnt, hs_first, blank_fall, vs_cnt, last_fs, n_fs;
        cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        cfg_s = '{S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 1'b1};
        mx_d = 0; my_d = 0; mx_s = 0; my_s = 0; fc_d = 8'd0; fc_s = 8'd0;

        // Reset held for 3 edges.
        for (int i = 0; i < 3; i++) step(1'b1);
        check("d_rst_hs",    32'(if_d.hs),    32'd1);
        check("d_rst_vs",    32'(if_d.vs),    32'd1);
        check("d_rst_blank", 32'(if_d.blank), 32'd0);
        check("s_rst_hs",    32'(if_s.hs),    32'd0);

        // First default line after release, measuring hs and blank against fixed timing.
        hs_cnt = 0; hs_first = -1; blank_fall = -1; vs_cnt = 0; last_fs = -1;
        for (int i = 0; i < 800; i++) begin
            step(1'b0);
            if (i == 0) begin
                check("d_first_x",     32'(if_d.DrawX),       32'd0);
                check("d_first_y",     32'(if_d.DrawY),       32'd0);
                check("d_first_blank", 32'(if_d.blank),       32'd1);
                check("d_first_fs",    32'(if_d.frame_start), 32'd1);
            end
            if (!if_d.hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_d.DrawX);
            end
            if (!if_d.blank && blank_fall < 0) blank_fall = int'(if_d.DrawX);
            if (i < 160 && if_s.vs) vs_cnt++;
            if (if_s.frame_start) begin
                if (last_fs >= 0) check("s_frame_period", 32'(i - last_fs), 32'd160);
                last_fs = i;
            end
        end
        check("d_hs_width",   32'(hs_cnt),     32'd96);
        check("d_hs_first",   32'(hs_first),   32'd656);
        check("d_blank_fall", 32'(blank_fall), 32'd640);
        check("s_vs_cycles",  32'(vs_cnt),     32'd32);

        // Line wrap 799 -> 0.
        step(1'b0);
        check("d_wrap_x",  32'(if_d.DrawX),      32'd0);
        check("d_wrap_y",  32'(if_d.DrawY),      32'd1);
        check("d_wrap_ls", 32'(if_d.line_start), 32'd1);

        // One-cycle reset mid-line.
        run_until_x(300, 1000);
        step(1'b1);
        check("d_mid_rst_x",     32'(if_d.DrawX), 32'd0);
        check("d_mid_rst_blank", 32'(if_d.blank), 32'd0);
        step(1'b0);
        check("d_mid_rel_fs", 32'(if_d.frame_start), 32'd1);
        check("d_mid_rel_y",  32'(if_d.DrawY),       32'd0);

        // Reset during an active hs pulse must end the pulse immediately.
        run_until_x(700, 1000);
        check("d_hs_active_700", 32'(if_d.hs), 32'd0);
        step(1'b1);
        check("d_hs_cut", 32'(if_d.hs), 32'd1);
        step(1'b1);
        step(1'b0);
        check("d_hs_rel_fs", 32'(if_d.frame_start), 32'd1);
        check("d_hs_rel_x",  32'(if_d.DrawX),       32'd0);

        // 256 more small frames: frame_count walks 1..255 then wraps to 0.
        n_fs = 1;
`ifdef FRAME_COUNTER_EN
        check("s_fc_first", 32'(if_s.frame_count), 32'd1);
`endif
        for (int i = 0; i < 256 * 160; i++) begin
            step(1'b0);
            if (if_s.frame_start) begin
                n_fs++;
`ifdef FRAME_COUNTER_EN
                check("s_fc_run", 32'(if_s.frame_count), 32'(n_fs % 256));
`endif
            end
        end
        check("s_fs_pulses", 32'(n_fs), 32'd257);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
